eth_rx_frame_check: RTL and testbench
=====================================

// Module: eth_rx_frame_check
// PURPOSE
//  Consumes the byte stream leaving the RGMII receive FIFO (clk125MHz domain), strips preamble/SFD,
//  checks Ethernet FCS (CRC-32), length and PHY error, and emits payload bytes (DA..last data byte,
//  FCS removed) with first/last markers and a per-frame good/bad verdict. No backpressure: the
//  upstream FIFO cannot stall, so this block never stalls either. Feeds the MAC/UDP parser.
// PARAMETERS
//  MIN_FRAME     64    minimum legal length in bytes, DA..FCS inclusive
//  MAX_FRAME     1518  maximum legal length in bytes, DA..FCS inclusive
//  MIN_PREAMBLE  1     minimum count of 0x55 bytes required before SFD
// PORTS
//  clk125MHz    in   1   sole clock; all ports synchronous to its rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  rx_data      in   8   byte from RX FIFO
//  rx_dv        in   1   data enable from RX FIFO; high for the whole frame incl. preamble
//  rx_er        in   1   PHY receive error, already in clk125MHz domain
//  m_data       out  8   payload byte
//  m_valid      out  1   m_data valid this cycle
//  m_first      out  1   with m_valid: first byte of DA
//  m_last       out  1   with m_valid: final payload byte of frame (FCS excluded)
//  m_good       out  1   with m_last: CRC ok, length in range, no rx_er
//  m_bad        out  1   with m_last: frame must be discarded; never high with m_good
//  cnt_good     out  32  frames ended with m_good (wraps)
//  cnt_bad      out  32  frames ended with m_bad, plus runts producing no output (wraps)
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, FSM IDLE, CRC = 0xFFFFFFFF, delay line empty.
//  FSM (one byte per cycle while rx_dv=1):
//   IDLE: rx_dv=1 & byte=0x55 -> PREAMBLE (count=1); rx_dv=1 & other byte -> DROP.
//   PREAMBLE: 0x55 -> count++; 0xD5 & count>=MIN_PREAMBLE -> PAYLOAD; any other byte or
//     premature SFD -> DROP; rx_dv=0 -> IDLE, no counter change.
//   PAYLOAD: each byte updates CRC and len (12-bit, saturating at 4095) and enters 5-deep
//     delay line. rx_dv=0 -> end of frame (below) -> IDLE. len reaching MAX_FRAME+1 -> forced end
//     with m_bad, then DROP.
//   DROP: ignore bytes until rx_dv=0 -> IDLE. No outputs.
//  CRC: reflected poly 0xEDB88320, LSB-first, init 0xFFFFFFFF at SFD; frame correct iff register
//   equals residue 0xDEBB20E3 after the last FCS byte. Byte-wide combinational update, registered.
//  Delay line: byte N (N=0 is first DA byte) is output registered in the cycle after byte N+5 is
//   accepted (m_valid=1, m_first=1 for N=0). Thus 4 FCS bytes plus one payload byte remain held.
//  End of frame (first cycle rx_dv=0 in PAYLOAD): if delay line holds 5 bytes, next cycle
//   outputs the oldest with m_valid=m_last=1 and exactly one of m_good/m_bad; FCS bytes dropped.
//   m_good = CRC residue match & MIN_FRAME<=len<=MAX_FRAME & no rx_er since SFD.
//   If fewer than 5 bytes received: no output beat, cnt_bad++.
//   Counters increment in the same cycle as the m_last beat.
//  rx_er any time in PAYLOAD: sticky error flag, frame continues, ends m_bad.
//  rx_dv low for a single cycle ends the frame; a new preamble may start the next cycle.
//  Back-to-back frames: last beat of frame k and first beats of frame k+1 never collide, since
//   k+1 needs >=7 bytes before its first output.
//  A 1-byte frame (5 held bytes) outputs that byte with m_first=m_last=1.
//  rst_n low mid-frame: outputs clear immediately, no m_last emitted, partial frame not counted;
//   after release, bytes of the interrupted frame are ignored until rx_dv=0 (start in DROP if
//   rx_dv=1 at first clock after release).
// TESTING
//  1 7x0x55,0xD5, 60-byte payload + correct FCS -> 60 beats, first on DA[0], m_last+m_good
//    on byte 59, cnt_good=1, latency SFD->first beat = 6 cycles.
//  2 Same frame, one payload bit flipped -> identical 60 beats, m_last with m_bad, cnt_bad=1.
//  3 Valid 40-byte frame (36 payload+FCS, good CRC) -> m_bad (runt); 3-byte frame -> no beats,
//    cnt_bad=1.
//  4 1519-byte frame -> m_last+m_bad on beat at len=MAX_FRAME+1 boundary, rest dropped, then
//    next good frame after one idle cycle -> m_good.
//  5 rx_er pulse mid-payload of good-CRC frame -> m_bad; preamble 0x55,0x54,... -> DROP, no beats.
//  6 rst_n asserted mid-payload -> outputs 0 same cycle, counters 0; release with rx_dv=1 ->
//    nothing emitted until rx_dv falls; next frame processed normally.

Source files
------------

// File: rtl/eth_rx_frame_check.sv
// Ethernet receive frame checker: strips preamble/SFD, checks CRC-32, length and PHY error,
// and streams DA..last data byte with first/last markers and a good/bad verdict.
module eth_rx_frame_check #(
  parameter int unsigned MIN_FRAME    = 64,
  parameter int unsigned MAX_FRAME    = 1518,
  parameter int unsigned MIN_PREAMBLE = 1
) (
  input  logic        clk125MHz,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_first,
  output logic        m_last,
  output logic        m_good,
  output logic        m_bad,
  output logic [31:0] cnt_good,
  output logic [31:0] cnt_bad
);

  localparam logic [31:0] CrcPoly    = 32'hEDB88320;
  localparam logic [31:0] CrcResidue = 32'hDEBB20E3;
  localparam logic [7:0]  PreByte    = 8'h55;
  localparam logic [7:0]  SfdByte    = 8'hD5;

  typedef enum logic [1:0] {StIdle, StPreamble, StPayload, StDrop} state_e;

  state_e          state_q, state_d;
  logic [3:0]      pre_cnt_q, pre_cnt_d;
  logic [31:0]     crc_q, crc_d;
  logic [11:0]     len_q, len_d;
  logic            err_q, err_d;
  logic [4:0][7:0] dl_q, dl_d;       // dl_q[4] is the oldest held byte
  logic [2:0]      dl_cnt_q, dl_cnt_d;
  logic            sent_q, sent_d;   // first beat of this frame already emitted
  logic            fresh_q, fresh_d; // first clock after reset release
  logic [7:0]      m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d;
  logic            m_first_q, m_first_d;
  logic            m_last_q, m_last_d;
  logic            m_good_q, m_good_d;
  logic            m_bad_q, m_bad_d;
  logic [31:0]     cnt_good_q, cnt_good_d;
  logic [31:0]     cnt_bad_q, cnt_bad_d;
  logic [11:0]     len_nxt;
  logic            frame_ok;

  // Reflected CRC-32, one byte LSB-first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
    end
    return c;
  endfunction

  assign len_nxt  = (len_q == 12'hFFF) ? len_q : len_q + 12'd1;
  assign frame_ok = (crc_q == CrcResidue) && (32'(len_q) >= MIN_FRAME) &&
                    (32'(len_q) <= MAX_FRAME) && !err_q;

  // Next-state: FSM, CRC/length tracking, delay line and registered output beat.
  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    crc_d      = crc_q;
    len_d      = len_q;
    err_d      = err_q;
    dl_d       = dl_q;
    dl_cnt_d   = dl_cnt_q;
    sent_d     = sent_q;
    fresh_d    = 1'b0;
    m_data_d   = m_data_q;
    m_valid_d  = 1'b0;
    m_first_d  = 1'b0;
    m_last_d   = 1'b0;
    m_good_d   = 1'b0;
    m_bad_d    = 1'b0;
    cnt_good_d = cnt_good_q;
    cnt_bad_d  = cnt_bad_q;

    unique case (state_q)
      StIdle: begin
        if (rx_dv) begin
          // A frame already in flight at reset release is skipped entirely.
          if (!fresh_q && rx_data == PreByte) begin
            state_d   = StPreamble;
            pre_cnt_d = 4'd1;
          end else begin
            state_d = StDrop;
          end
        end
      end
      StPreamble: begin
        if (!rx_dv) begin
          state_d = StIdle;
        end else if (rx_data == PreByte) begin
          pre_cnt_d = (pre_cnt_q == 4'hF) ? pre_cnt_q : pre_cnt_q + 4'd1;
        end else if (rx_data == SfdByte && 32'(pre_cnt_q) >= MIN_PREAMBLE) begin
          state_d  = StPayload;
          crc_d    = 32'hFFFFFFFF;
          len_d    = 12'd0;
          err_d    = 1'b0;
          dl_cnt_d = 3'd0;
          sent_d   = 1'b0;
        end else begin
          state_d = StDrop;
        end
      end
      StPayload: begin
        if (!rx_dv) begin
          state_d  = StIdle;
          dl_cnt_d = 3'd0;
          if (dl_cnt_q == 3'd5) begin
            m_data_d  = dl_q[4];
            m_valid_d = 1'b1;
            m_first_d = !sent_q;
            m_last_d  = 1'b1;
            m_good_d  = frame_ok;
            m_bad_d   = !frame_ok;
            if (frame_ok) cnt_good_d = cnt_good_q + 32'd1;
            else          cnt_bad_d  = cnt_bad_q + 32'd1;
          end else begin
            cnt_bad_d = cnt_bad_q + 32'd1;
          end
        end else begin
          crc_d = crc_byte(crc_q, rx_data);
          len_d = len_nxt;
          if (rx_er) err_d = 1'b1;
          dl_d = {dl_q[3:0], rx_data};
          if (dl_cnt_q == 3'd5) begin
            m_data_d  = dl_q[4];
            m_valid_d = 1'b1;
            m_first_d = !sent_q;
            sent_d    = 1'b1;
          end else begin
            dl_cnt_d = dl_cnt_q + 3'd1;
          end
          // Oversize: close the frame on the current beat and discard the rest.
          if (32'(len_nxt) == MAX_FRAME + 1) begin
            state_d   = StDrop;
            dl_cnt_d  = 3'd0;
            m_last_d  = (dl_cnt_q == 3'd5);
            m_bad_d   = (dl_cnt_q == 3'd5);
            cnt_bad_d = cnt_bad_q + 32'd1;
          end
        end
      end
      StDrop: begin
        if (!rx_dv) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk125MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pre_cnt_q  <= 4'd0;
      crc_q      <= 32'hFFFFFFFF;
      len_q      <= 12'd0;
      err_q      <= 1'b0;
      dl_q       <= '0;
      dl_cnt_q   <= 3'd0;
      sent_q     <= 1'b0;
      fresh_q    <= 1'b1;
      m_data_q   <= 8'd0;
      m_valid_q  <= 1'b0;
      m_first_q  <= 1'b0;
      m_last_q   <= 1'b0;
      m_good_q   <= 1'b0;
      m_bad_q    <= 1'b0;
      cnt_good_q <= 32'd0;
      cnt_bad_q  <= 32'd0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      crc_q      <= crc_d;
      len_q      <= len_d;
      err_q      <= err_d;
      dl_q       <= dl_d;
      dl_cnt_q   <= dl_cnt_d;
      sent_q     <= sent_d;
      fresh_q    <= fresh_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_first_q  <= m_first_d;
      m_last_q   <= m_last_d;
      m_good_q   <= m_good_d;
      m_bad_q    <= m_bad_d;
      cnt_good_q <= cnt_good_d;
      cnt_bad_q  <= cnt_bad_d;
    end
  end

  assign m_data   = m_data_q;
  assign m_valid  = m_valid_q;
  assign m_first  = m_first_q;
  assign m_last   = m_last_q;
  assign m_good   = m_good_q;
  assign m_bad    = m_bad_q;
  assign cnt_good = cnt_good_q;
  assign cnt_bad  = cnt_bad_q;

endmodule

// File: tb/tb_eth_rx_frame_check.sv
// Table-driven bench for eth_rx_frame_check with hand-written reset-in-frame sequence.
module tb_eth_rx_frame_check;

  logic        clk125MHz = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_dv;
  logic        rx_er;
  logic [7:0]  m_data;
  logic        m_valid, m_first, m_last, m_good, m_bad;
  logic [31:0] cnt_good, cnt_bad;

  always #4 clk125MHz = ~clk125MHz;

  eth_rx_frame_check dut (
    .clk125MHz (clk125MHz),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_dv     (rx_dv),
    .rx_er     (rx_er),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_first   (m_first),
    .m_last    (m_last),
    .m_good    (m_good),
    .m_bad     (m_bad),
    .cnt_good  (cnt_good),
    .cnt_bad   (cnt_bad)
  );

  typedef struct {
    int pre;     // 0x55 count before SFD
    int plen;    // DA..last data byte
    int fcs;     // append correct FCS
    int flip;    // flip a payload bit after FCS computed
    int er_at;   // byte index carrying rx_er, -1 none
    int bad_pre; // start with 0x55,0x54
    int gap;     // idle cycles after frame
    int nbeats;
    int good;
    int dg;
    int db;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic first, last, good, bad;
    int   cyc;
  } beat_t;

  vec_t       vecs[13];
  beat_t      beats[$];
  logic [7:0] frm[0:2047];
  int         flen;
  int         cyc = 0;
  int         sfd_cyc;
  int         checks = 0;
  int         errors = 0;
  int         exp_cg = 0;
  int         exp_cb = 0;

  always @(posedge clk125MHz) cyc <= cyc + 1;

  // Collect output beats mid-cycle.
  always @(negedge clk125MHz) begin
    if (m_valid) begin
      beat_t b;
      b.data = m_data; b.first = m_first; b.last = m_last;
      b.good = m_good; b.bad = m_bad; b.cyc = cyc;
      beats.push_back(b);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic dv, input logic er);
    rx_data = d; rx_dv = dv; rx_er = er;
    @(posedge clk125MHz);
    #1;
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r  = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic build_frame(input vec_t v, input int seed);
    logic [31:0] c;
    logic [31:0] f;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < v.plen; i++) begin
      frm[i] = 8'((i * 13 + seed) & 255);
      c = crc_step(c, frm[i]);
    end
    f    = ~c;
    flen = v.plen;
    if (v.fcs != 0) begin
      for (int k = 0; k < 4; k++) frm[v.plen + k] = f[8*k +: 8];
      flen = v.plen + 4;
    end
    if (v.flip != 0) frm[5] = frm[5] ^ 8'h10;
  endtask

  task automatic send_frame(input vec_t v, input int seed);
    build_frame(v, seed);
    beats.delete();
    if (v.bad_pre != 0) begin
      drive(8'h55, 1'b1, 1'b0);
      drive(8'h54, 1'b1, 1'b0);
    end
    repeat (v.pre) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    sfd_cyc = cyc;
    for (int i = 0; i < flen; i++) drive(frm[i], 1'b1, (v.er_at == i));
    repeat (v.gap) drive(8'h00, 1'b0, 1'b0);
    @(negedge clk125MHz);
    #1;
  endtask

  task automatic check_frame(input vec_t v, input int idx);
    int derr, ferr;
    string s;
    derr = 0; ferr = 0;
    exp_cg += v.dg;
    exp_cb += v.db;
    s = $sformatf("v%0d", idx);
    check({s, "_beats"}, beats.size(), v.nbeats);
    for (int i = 0; i < beats.size(); i++) begin
      if (i < flen && beats[i].data != frm[i]) derr++;
      if (beats[i].first != (i == 0)) ferr++;
      if (beats[i].last != (i == v.nbeats - 1)) ferr++;
      if (!beats[i].last && (beats[i].good || beats[i].bad)) ferr++;
      if (beats[i].good && beats[i].bad) ferr++;
    end
    check({s, "_data"}, derr, 0);
    check({s, "_flags"}, ferr, 0);
    if (v.nbeats > 0 && beats.size() == v.nbeats) begin
      check({s, "_good"}, int'(beats[v.nbeats-1].good), v.good);
      check({s, "_bad"}, int'(beats[v.nbeats-1].bad), 1 - v.good);
      check({s, "_latency"}, beats[0].cyc - sfd_cyc, 6);
    end
    check({s, "_cnt_good"}, int'(cnt_good), exp_cg);
    check({s, "_cnt_bad"}, int'(cnt_bad), exp_cb);
  endtask

  initial begin
    //          pre plen  fcs flip er  bpre gap beats good dg db
    vecs[0]  = '{7, 60,   1,  0,  -1, 0,   3,  60,   1,   1, 0}; // good 64-byte frame
    vecs[1]  = '{7, 60,   1,  1,  -1, 0,   3,  60,   0,   0, 1}; // CRC error
    vecs[2]  = '{7, 36,   1,  0,  -1, 0,   3,  36,   0,   0, 1}; // runt, good CRC
    vecs[3]  = '{7, 3,    0,  0,  -1, 0,   3,  0,    0,   0, 1}; // 3 bytes, no beats
    vecs[4]  = '{7, 60,   1,  0,  30, 0,   3,  60,   0,   0, 1}; // rx_er pulse
    vecs[5]  = '{7, 60,   1,  0,  -1, 1,   3,  0,    0,   0, 0}; // bad preamble
    vecs[6]  = '{1, 60,   1,  0,  -1, 0,   1,  60,   1,   1, 0}; // min preamble
    vecs[7]  = '{7, 59,   1,  0,  -1, 0,   3,  59,   0,   0, 1}; // 63 bytes
    vecs[8]  = '{7, 1,    1,  0,  -1, 0,   3,  1,    0,   0, 1}; // 1-byte frame
    vecs[9]  = '{7, 1514, 1,  0,  -1, 0,   1,  1514, 1,   1, 0}; // 1518 bytes
    vecs[10] = '{7, 1515, 1,  0,  -1, 0,   1,  1514, 0,   0, 1}; // 1519 bytes forced end
    vecs[11] = '{7, 60,   1,  0,  -1, 0,   3,  60,   1,   1, 0}; // one idle cycle later
    vecs[12] = '{7, 0,    1,  0,  -1, 0,   3,  0,    0,   0, 1}; // 4 bytes, no beats

    rst_n = 1'b0; rx_data = 8'h00; rx_dv = 1'b0; rx_er = 1'b0;
    #1;
    check("rst_valid", int'(m_valid), 0);
    check("rst_cnt_good", int'(cnt_good), 0);
    check("rst_cnt_bad", int'(cnt_bad), 0);
    repeat (3) @(posedge clk125MHz);
    #1;
    rst_n = 1'b1;
    repeat (2) drive(8'h00, 1'b0, 1'b0);

    for (int v = 0; v < 13; v++) begin
      send_frame(vecs[v], v * 17);
      check_frame(vecs[v], v);
    end

    // Reset mid-payload, release while the interrupted frame is still arriving.
    build_frame(vecs[0], 5);
    repeat (7) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive(frm[i], 1'b1, 1'b0);
    check("pre_rst_valid", int'(m_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", int'(m_valid), 0);
    check("rst_mid_data", int'(m_data), 0);
    check("rst_mid_cnt_good", int'(cnt_good), 0);
    check("rst_mid_cnt_bad", int'(cnt_bad), 0);
    drive(frm[20], 1'b1, 1'b0);
    drive(frm[21], 1'b1, 1'b0);
    beats.delete();
    rst_n = 1'b1;
    for (int i = 22; i < flen; i++) drive(frm[i], 1'b1, 1'b0);
    repeat (2) drive(8'h00, 1'b0, 1'b0);
    @(negedge clk125MHz);
    #1;
    check("rst_tail_beats", beats.size(), 0);
    check("rst_tail_cnt_good", int'(cnt_good), 0);
    check("rst_tail_cnt_bad", int'(cnt_bad), 0);
    exp_cg = 0;
    exp_cb = 0;
    send_frame(vecs[0], 99);
    check_frame(vecs[0], 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
